// File: rtl/i2c_reg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_sequencer_if
// Purpose  : Single-access bus between the I2C register sequencer and the
//            wishbone_handler (begin/done handshake plus address/data).
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_reg_sequencer_if;
    logic       wbBegin;        // one-cycle access request
    logic       wbWriteEnable;  // 1 = write, 0 = read
    logic [7:0] wbAddress;      // EFB register address
    logic [7:0] wbWriteData;    // write byte
    logic       wbDone;         // handler completion, high for 2 cycles
    logic [7:0] wbReadData;     // read byte, valid while wbDone

    modport master (
        output wbBegin,
        output wbWriteEnable,
        output wbAddress,
        output wbWriteData,
        input  wbDone,
        input  wbReadData
    );

    modport slave (
        input  wbBegin,
        input  wbWriteEnable,
        input  wbAddress,
        input  wbWriteData,
        output wbDone,
        output wbReadData
    );
endinterface
`default_nettype wire

// File: rtl/i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_sequencer
// Purpose  : Turns one "access slave register" request into the EFB I2C1
//            register sequence (TXDR/CMDR writes, SR polls, RXDR read), one
//            wishbone_handler access per step. Single-byte write or read of
//            an 8-bit register on a 7-bit I2C slave; reports done, read data,
//            NACK and timeout.
// Options  : define I2C_INIT_EN to prefix the first transaction after reset
//            with CR/BR0/BR1 writes (baud prescaler from PRESCALE).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_reg_sequencer #(
    parameter logic [7:0] BASE_ADDR  = 8'h40,
    parameter int         POLL_LIMIT = 1024,
    parameter logic [9:0] PRESCALE   = 10'd60
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    input  wire logic       i_start,
    input  wire logic       i_read,
    input  wire logic [6:0] i_devAddr,
    input  wire logic [7:0] i_regAddr,
    input  wire logic [7:0] i_wrData,
    output logic            o_busy,
    output logic            o_done,
    output logic [7:0]      o_rdData,
    output logic            o_nack,
    output logic            o_timeout,
    i2c_reg_sequencer_if.master wb
);

    // FSM states
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ISSUE  = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_FINISH = 2'd3;

    // Step kinds
    localparam logic [1:0] c_KIND_WR   = 2'd0;
    localparam logic [1:0] c_KIND_POLL = 2'd1;
    localparam logic [1:0] c_KIND_RD   = 2'd2;

    // Poll conditions
    localparam logic [1:0] c_COND_TRRDY   = 2'd0;
    localparam logic [1:0] c_COND_SRW     = 2'd1;
    localparam logic [1:0] c_COND_BUSYCLR = 2'd2;

    // Abort reasons
    localparam logic [1:0] c_ABORT_NONE = 2'd0;
    localparam logic [1:0] c_ABORT_NACK = 2'd1;
    localparam logic [1:0] c_ABORT_TMO  = 2'd2;

    // Step indices outside the main 0..12 sequence
    localparam logic [4:0] c_STEP_STOP     = 5'd14;
    localparam logic [4:0] c_STEP_STOPWAIT = 5'd15;
    localparam logic [4:0] c_STEP_INIT0    = 5'd16;
    localparam logic [4:0] c_STEP_INIT2    = 5'd18;

    // EFB I2C1 register addresses
    localparam logic [7:0] c_ADDR_CR   = BASE_ADDR + 8'd0;
    localparam logic [7:0] c_ADDR_CMDR = BASE_ADDR + 8'd1;
    localparam logic [7:0] c_ADDR_BR0  = BASE_ADDR + 8'd2;
    localparam logic [7:0] c_ADDR_BR1  = BASE_ADDR + 8'd3;
    localparam logic [7:0] c_ADDR_TXDR = BASE_ADDR + 8'd4;
    localparam logic [7:0] c_ADDR_SR   = BASE_ADDR + 8'd5;
    localparam logic [7:0] c_ADDR_RXDR = BASE_ADDR + 8'd7;

    // CMDR command bytes
    localparam logic [7:0] c_CMD_STA_WR = 8'h94;
    localparam logic [7:0] c_CMD_WR     = 8'h14;
    localparam logic [7:0] c_CMD_STO    = 8'h44;
    localparam logic [7:0] c_CMD_RD_NAK = 8'h6C;

    localparam logic [10:0] c_POLL_LIMIT = 11'(POLL_LIMIT);

    // Registered state
    logic [1:0]  r_state_q,   w_state_d;
    logic [4:0]  r_step_q,    w_step_d;
    logic [10:0] r_pollCnt_q, w_pollCnt_d;
    logic [1:0]  r_abort_q,   w_abort_d;
    logic        r_read_q,    w_read_d;
    logic [6:0]  r_dev_q,     w_dev_d;
    logic [7:0]  r_reg_q,     w_reg_d;
    logic [7:0]  r_data_q,    w_data_d;
    logic [7:0]  r_rx_q,      w_rx_d;
    logic [7:0]  r_rdData_q,  w_rdData_d;
    logic        r_nack_q,    w_nack_d;
    logic        r_timeout_q, w_timeout_d;
    logic        r_seenLow_q, w_seenLow_d;
    logic        r_wbDonePrev_q;
`ifdef I2C_INIT_EN
    logic        r_initDone_q, w_initDone_d;
`endif

    // Step table decode
    logic [1:0]  w_kind;
    logic        w_stepWe;
    logic [7:0]  w_stepAddr;
    logic [7:0]  w_stepData;
    logic [1:0]  w_cond;
    logic        w_nackChk;
    logic        w_lastStep;
    logic [4:0]  w_stepNext;

    // Handshake helpers
    logic        w_wbRise;
    logic        w_canIssue;
    logic        w_condMet;
    logic [10:0] w_cntInc;
    logic        w_advance;

    assign w_wbRise   = wb.wbDone & ~r_wbDonePrev_q;
    // A new access may start only once the previous done pulse has dropped;
    // after reset the seen-low flag is clear, so an in-flight done drains first.
    assign w_canIssue = r_seenLow_q | ~wb.wbDone;
    assign w_cntInc   = r_pollCnt_q + 11'd1;

    // State register and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q      <= c_ST_IDLE;
            r_step_q       <= 5'd0;
            r_pollCnt_q    <= 11'd0;
            r_abort_q      <= c_ABORT_NONE;
            r_read_q       <= 1'b0;
            r_dev_q        <= 7'd0;
            r_reg_q        <= 8'd0;
            r_data_q       <= 8'd0;
            r_rx_q         <= 8'd0;
            r_rdData_q     <= 8'd0;
            r_nack_q       <= 1'b0;
            r_timeout_q    <= 1'b0;
            r_seenLow_q    <= 1'b0;
            r_wbDonePrev_q <= 1'b0;
`ifdef I2C_INIT_EN
            r_initDone_q   <= 1'b0;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_step_q       <= w_step_d;
            r_pollCnt_q    <= w_pollCnt_d;
            r_abort_q      <= w_abort_d;
            r_read_q       <= w_read_d;
            r_dev_q        <= w_dev_d;
            r_reg_q        <= w_reg_d;
            r_data_q       <= w_data_d;
            r_rx_q         <= w_rx_d;
            r_rdData_q     <= w_rdData_d;
            r_nack_q       <= w_nack_d;
            r_timeout_q    <= w_timeout_d;
            r_seenLow_q    <= w_seenLow_d;
            r_wbDonePrev_q <= wb.wbDone;
`ifdef I2C_INIT_EN
            r_initDone_q   <= w_initDone_d;
`endif
        end
    end

    // Done-seen-low tracking: cleared by each completion edge
    always_comb begin
        w_seenLow_d = r_seenLow_q;
        if (!wb.wbDone) begin
            w_seenLow_d = 1'b1;
        end else if (w_wbRise) begin
            w_seenLow_d = 1'b0;
        end
    end

    // Step table: what access the current step performs
    always_comb begin
        w_kind     = c_KIND_WR;
        w_stepWe   = 1'b1;
        w_stepAddr = c_ADDR_CMDR;
        w_stepData = 8'h00;
        w_cond     = c_COND_TRRDY;
        w_nackChk  = 1'b0;
        case (r_step_q)
            5'd0:  begin w_stepAddr = c_ADDR_TXDR; w_stepData = {r_dev_q, 1'b0}; end
            5'd1:  w_stepData = c_CMD_STA_WR;
            5'd2:  begin w_kind = c_KIND_POLL; w_nackChk = 1'b1; end
            5'd3:  begin w_stepAddr = c_ADDR_TXDR; w_stepData = r_reg_q; end
            5'd4:  w_stepData = c_CMD_WR;
            5'd5:  begin w_kind = c_KIND_POLL; w_nackChk = 1'b1; end
            5'd6:  begin
                w_stepAddr = c_ADDR_TXDR;
                w_stepData = r_read_q ? {r_dev_q, 1'b1} : r_data_q;
            end
            5'd7:  w_stepData = r_read_q ? c_CMD_STA_WR : c_CMD_WR;
            5'd8:  begin
                w_kind    = c_KIND_POLL;
                w_cond    = r_read_q ? c_COND_SRW : c_COND_TRRDY;
                w_nackChk = ~r_read_q;
            end
            5'd9:  w_stepData = r_read_q ? c_CMD_RD_NAK : c_CMD_STO;
            // Read: byte-received poll (master drives the ACK, so no RARC check)
            5'd10: begin
                w_kind = c_KIND_POLL;
                w_cond = r_read_q ? c_COND_TRRDY : c_COND_BUSYCLR;
            end
            5'd11: w_kind = c_KIND_RD;
            5'd12: begin w_kind = c_KIND_POLL; w_cond = c_COND_BUSYCLR; end
            5'd14: w_stepData = c_CMD_STO;
            5'd15: begin w_kind = c_KIND_POLL; w_cond = c_COND_BUSYCLR; end
            5'd16: begin w_stepAddr = c_ADDR_CR;  w_stepData = 8'h80; end
            5'd17: begin w_stepAddr = c_ADDR_BR0; w_stepData = PRESCALE[7:0]; end
            5'd18: begin w_stepAddr = c_ADDR_BR1; w_stepData = {6'b0, PRESCALE[9:8]}; end
            default: ;
        endcase
        if (w_kind == c_KIND_POLL) begin
            w_stepWe   = 1'b0;
            w_stepAddr = c_ADDR_SR;
        end else if (w_kind == c_KIND_RD) begin
            w_stepWe   = 1'b0;
            w_stepAddr = c_ADDR_RXDR;
        end
    end

    // Sequence successor and end-of-sequence detection
    always_comb begin
        w_lastStep = 1'b0;
        w_stepNext = r_step_q + 5'd1;
        case (r_step_q)
            5'd10: w_lastStep = ~r_read_q;
            5'd12: w_lastStep = 1'b1;
            5'd14: w_lastStep = (r_abort_q == c_ABORT_TMO);
            5'd15: w_lastStep = 1'b1;
            c_STEP_INIT2: w_stepNext = 5'd0;
            default: ;
        endcase
    end

    // Poll condition on the freshly returned SR byte
    always_comb begin
        case (w_cond)
            c_COND_SRW:     w_condMet = wb.wbReadData[4];
            c_COND_BUSYCLR: w_condMet = ~wb.wbReadData[6];
            default:        w_condMet = wb.wbReadData[2];
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_d   = r_state_q;
        w_step_d    = r_step_q;
        w_pollCnt_d = r_pollCnt_q;
        w_abort_d   = r_abort_q;
        w_read_d    = r_read_q;
        w_dev_d     = r_dev_q;
        w_reg_d     = r_reg_q;
        w_data_d    = r_data_q;
        w_rx_d      = r_rx_q;
        w_rdData_d  = r_rdData_q;
        w_nack_d    = r_nack_q;
        w_timeout_d = r_timeout_q;
        w_advance   = 1'b0;
`ifdef I2C_INIT_EN
        w_initDone_d = r_initDone_q;
`endif
        case (r_state_q)
            c_ST_IDLE: begin
                if (i_start) begin
                    w_read_d    = i_read;
                    w_dev_d     = i_devAddr;
                    w_reg_d     = i_regAddr;
                    w_data_d    = i_wrData;
                    w_nack_d    = 1'b0;
                    w_timeout_d = 1'b0;
                    w_abort_d   = c_ABORT_NONE;
                    w_pollCnt_d = 11'd0;
`ifdef I2C_INIT_EN
                    w_step_d     = r_initDone_q ? 5'd0 : c_STEP_INIT0;
                    w_initDone_d = 1'b1;
`else
                    w_step_d    = 5'd0;
`endif
                    w_state_d   = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (w_canIssue) begin
                    w_state_d = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (w_wbRise) begin
                    case (w_kind)
                        c_KIND_RD: begin
                            w_rx_d    = wb.wbReadData;
                            w_advance = 1'b1;
                        end
                        c_KIND_POLL: begin
                            // NACK outranks timeout on the same SR read
                            if (w_nackChk && r_abort_q == c_ABORT_NONE && wb.wbReadData[5]) begin
                                w_abort_d   = c_ABORT_NACK;
                                w_step_d    = c_STEP_STOP;
                                w_pollCnt_d = 11'd0;
                                w_state_d   = c_ST_ISSUE;
                            end else if (w_condMet) begin
                                w_advance = 1'b1;
                            end else if (w_cntInc >= c_POLL_LIMIT) begin
                                if (r_abort_q == c_ABORT_NONE) begin
                                    w_abort_d   = c_ABORT_TMO;
                                    w_step_d    = c_STEP_STOP;
                                    w_pollCnt_d = 11'd0;
                                    w_state_d   = c_ST_ISSUE;
                                end else begin
                                    // STOP after NACK never settled: give up, keep NACK
                                    w_state_d = c_ST_FINISH;
                                end
                            end else begin
                                w_pollCnt_d = w_cntInc;
                                w_state_d   = c_ST_ISSUE;
                            end
                        end
                        default: w_advance = 1'b1;
                    endcase
                    if (w_advance) begin
                        if (w_lastStep) begin
                            w_state_d = c_ST_FINISH;
                        end else begin
                            w_step_d    = w_stepNext;
                            w_pollCnt_d = 11'd0;
                            w_state_d   = c_ST_ISSUE;
                        end
                    end
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
        // Status outputs change only as the done pulse starts
        if (w_state_d == c_ST_FINISH && r_state_q != c_ST_FINISH) begin
            w_nack_d    = (w_abort_d == c_ABORT_NACK);
            w_timeout_d = (w_abort_d == c_ABORT_TMO);
            if (r_read_q && w_abort_d == c_ABORT_NONE) begin
                w_rdData_d = w_rx_d;
            end
        end
    end

    // Output decode
    always_comb begin
        o_busy           = (r_state_q == c_ST_ISSUE) || (r_state_q == c_ST_WAIT);
        o_done           = (r_state_q == c_ST_FINISH);
        wb.wbBegin       = (r_state_q == c_ST_ISSUE) && w_canIssue;
        wb.wbWriteEnable = 1'b0;
        wb.wbAddress     = 8'h00;
        wb.wbWriteData   = 8'h00;
        if (o_busy) begin
            wb.wbWriteEnable = w_stepWe;
            wb.wbAddress     = w_stepAddr;
            wb.wbWriteData   = w_stepWe ? w_stepData : 8'h00;
        end
    end

    assign o_rdData  = r_rdData_q;
    assign o_nack    = r_nack_q;
    assign o_timeout = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_reg_sequencer
// Purpose  : Directed bench for i2c_reg_sequencer with a behavioural
//            wishbone_handler + EFB model that logs every access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rd = 1'b0;
    logic [6:0] dev = 7'd0;
    logic [7:0] regA = 8'd0;
    logic [7:0] wdat = 8'd0;
    logic       busy, done, nack, tmo;
    logic [7:0] rdData;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_reg_sequencer_if wb_if ();

    i2c_reg_sequencer #(
        .BASE_ADDR (8'h40),
        .POLL_LIMIT(8),
        .PRESCALE  (10'h13C)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_read   (rd),
        .i_devAddr(dev),
        .i_regAddr(regA),
        .i_wrData (wdat),
        .o_busy   (busy),
        .o_done   (done),
        .o_rdData (rdData),
        .o_nack   (nack),
        .o_timeout(tmo),
        .wb       (wb_if)
    );

    always #5 clk = ~clk;

    // ---------------- handler + EFB model ----------------
    logic [16:0] log_q [0:255];
    int          log_n    = 0;
    int          sr_total = 0;
    int          sr_base  = 0;
    int          viol     = 0;
    int          mcnt     = 0;
    int          mode     = 0;   // 0 ack, 1 RARC on first poll, 2 never ready
    logic [7:0]  maddr    = 8'h00;
    logic        m_done   = 1'b0;
    logic [7:0]  m_rdata  = 8'h00;
    int          done_cnt = 0;

    assign wb_if.wbDone     = m_done;
    assign wb_if.wbReadData = m_rdata;

    function automatic logic [7:0] sr_value(input int idx);
        case (mode)
            1:       return (idx == 0) ? 8'h24 : 8'h14;
            2:       return 8'h40;
            default: return 8'h14;
        endcase
    endfunction

    function automatic logic [16:0] W(input logic [7:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [16:0] R(input logic [7:0] a);
        return {1'b0, a, 8'h00};
    endfunction

    always @(posedge clk) begin
        if (wb_if.wbBegin) begin
            if (m_done) viol <= viol + 1;
            if (log_n < 256)
                log_q[log_n] <= {wb_if.wbWriteEnable, wb_if.wbAddress,
                                 wb_if.wbWriteEnable ? wb_if.wbWriteData : 8'h00};
            log_n <= log_n + 1;
            maddr <= wb_if.wbAddress;
            mcnt  <= 1;
        end else begin
            case (mcnt)
                1: mcnt <= 2;
                2: begin
                    m_done <= 1'b1;
                    if (maddr == 8'h45) begin
                        m_rdata  <= sr_value(sr_total - sr_base);
                        sr_total <= sr_total + 1;
                    end else if (maddr == 8'h47) begin
                        m_rdata <= 8'h3C;
                    end else begin
                        m_rdata <= 8'h00;
                    end
                    mcnt <= 3;
                end
                3: mcnt <= 4;
                4: begin m_done <= 1'b0; mcnt <= 0; end
                default: ;
            endcase
        end
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    // ---------------- stimulus helpers ----------------
    task automatic start_txn(input logic r, input logic [6:0] d,
                             input logic [7:0] ra, input logic [7:0] wd);
        @(negedge clk);
        rd = r; dev = d; regA = ra; wdat = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for o_done; returns the status seen on the done cycle
    task automatic wait_done(input string name, output logic b, output logic n,
                             output logic t, output logic [7:0] r);
        bit seen = 0;
        b = 1'bx; n = 1'bx; t = 1'bx; r = 8'hxx;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1; b = busy; n = nack; t = tmo; r = rdData;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_done_timeout: no o_done within 3000 cycles", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if ({nack, tmo, rdData} !== 10'd0) begin n_bad++; $display("FAIL reset_status got %b want 0", {nack, tmo, rdData}); end
        n_cmp++;
        if ({wb_if.wbBegin, wb_if.wbWriteEnable, wb_if.wbAddress, wb_if.wbWriteData} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_wb got %h want 0",
                     {wb_if.wbBegin, wb_if.wbWriteEnable, wb_if.wbAddress, wb_if.wbWriteData});
        end
    endtask

`ifdef I2C_INIT_EN
    task automatic test_init();
        logic [16:0] exp[$];
        logic b, n, t; logic [7:0] r;
        int base = log_n;
        mode = 0;
        exp = {W(8'h40,8'h80), W(8'h42,8'h3C), W(8'h43,8'h01),
               W(8'h44,8'h90), W(8'h41,8'h94), R(8'h45), W(8'h44,8'h01), W(8'h41,8'h14),
               R(8'h45), W(8'h44,8'hA5), W(8'h41,8'h14), R(8'h45), W(8'h41,8'h44), R(8'h45)};
        start_txn(1'b0, 7'h48, 8'h01, 8'hA5);
        wait_done("init", b, n, t, r);
        repeat (20) @(negedge clk);
        n_cmp++; if (log_n - base !== exp.size()) begin n_bad++; $display("FAIL init_count got %0d want %0d", log_n - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (log_q[base+i] !== exp[i]) begin n_bad++; $display("FAIL init_log[%0d] got %h want %h", i, log_q[base+i], exp[i]); end
        end
    endtask
`endif

    task automatic test_write();
        logic [16:0] exp[$];
        logic b, n, t; logic [7:0] r;
        int base = log_n;
        int dbase = done_cnt;
        mode = 0;
        exp = {W(8'h44,8'h90), W(8'h41,8'h94), R(8'h45), W(8'h44,8'h01), W(8'h41,8'h14),
               R(8'h45), W(8'h44,8'hA5), W(8'h41,8'h14), R(8'h45), W(8'h41,8'h44), R(8'h45)};
        start_txn(1'b0, 7'h48, 8'h01, 8'hA5);
        wait_done("write", b, n, t, r);
        repeat (20) @(negedge clk);
        n_cmp++; if (b !== 1'b0) begin n_bad++; $display("FAIL write_busy_at_done got %b want 0", b); end
        n_cmp++; if ({n, t} !== 2'b00) begin n_bad++; $display("FAIL write_nack_tmo got %b want 00", {n, t}); end
        n_cmp++; if (done_cnt - dbase !== 1) begin n_bad++; $display("FAIL write_done_pulses got %0d want 1", done_cnt - dbase); end
        n_cmp++; if (log_n - base !== exp.size()) begin n_bad++; $display("FAIL write_count got %0d want %0d", log_n - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (log_q[base+i] !== exp[i]) begin n_bad++; $display("FAIL write_log[%0d] got %h want %h", i, log_q[base+i], exp[i]); end
        end
    endtask

    task automatic test_read();
        logic [16:0] exp[$];
        logic b, n, t; logic [7:0] r;
        int base = log_n;
        mode = 0;
        exp = {W(8'h44,8'h90), W(8'h41,8'h94), R(8'h45), W(8'h44,8'h00), W(8'h41,8'h14), R(8'h45),
               W(8'h44,8'h91), W(8'h41,8'h94), R(8'h45), W(8'h41,8'h6C), R(8'h45), R(8'h47), R(8'h45)};
        start_txn(1'b1, 7'h48, 8'h00, 8'h00);
        wait_done("read", b, n, t, r);
        repeat (20) @(negedge clk);
        n_cmp++; if (r !== 8'h3C) begin n_bad++; $display("FAIL read_data got %h want 3c", r); end
        n_cmp++; if ({n, t} !== 2'b00) begin n_bad++; $display("FAIL read_nack_tmo got %b want 00", {n, t}); end
        n_cmp++; if (log_n - base !== exp.size()) begin n_bad++; $display("FAIL read_count got %0d want %0d", log_n - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (log_q[base+i] !== exp[i]) begin n_bad++; $display("FAIL read_log[%0d] got %h want %h", i, log_q[base+i], exp[i]); end
        end
    endtask

    task automatic test_nack();
        logic [16:0] exp[$];
        logic b, n, t; logic [7:0] r;
        int base = log_n;
        mode = 1; sr_base = sr_total;
        exp = {W(8'h44,8'h90), W(8'h41,8'h94), R(8'h45), W(8'h41,8'h44), R(8'h45)};
        start_txn(1'b0, 7'h48, 8'h01, 8'hA5);
        wait_done("nack", b, n, t, r);
        repeat (20) @(negedge clk);
        n_cmp++; if ({n, t} !== 2'b10) begin n_bad++; $display("FAIL nack_flags got %b want 10", {n, t}); end
        n_cmp++; if (log_n - base !== exp.size()) begin n_bad++; $display("FAIL nack_count got %0d want %0d", log_n - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (log_q[base+i] !== exp[i]) begin n_bad++; $display("FAIL nack_log[%0d] got %h want %h", i, log_q[base+i], exp[i]); end
        end
    endtask

    task automatic test_timeout();
        logic [16:0] exp[$];
        logic b, n, t; logic [7:0] r;
        int base = log_n;
        mode = 2; sr_base = sr_total;
        exp = {W(8'h44,8'h90), W(8'h41,8'h94)};
        for (int i = 0; i < 8; i++) exp.push_back(R(8'h45));
        exp.push_back(W(8'h41,8'h44));
        start_txn(1'b0, 7'h48, 8'h01, 8'hA5);
        wait_done("timeout", b, n, t, r);
        repeat (20) @(negedge clk);
        n_cmp++; if ({n, t} !== 2'b01) begin n_bad++; $display("FAIL timeout_flags got %b want 01", {n, t}); end
        n_cmp++; if (r !== 8'h3C) begin n_bad++; $display("FAIL timeout_rddata_held got %h want 3c", r); end
        n_cmp++; if (log_n - base !== exp.size()) begin n_bad++; $display("FAIL timeout_count got %0d want %0d", log_n - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (log_q[base+i] !== exp[i]) begin n_bad++; $display("FAIL timeout_log[%0d] got %h want %h", i, log_q[base+i], exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic b, n, t; logic [7:0] r;
        int base = log_n;
        int dbase = done_cnt;
        mode = 0;
        start_txn(1'b0, 7'h48, 8'h01, 8'hA5);
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %b want 1", busy); end
        rd = 1'b0; dev = 7'h22; regA = 8'h33; wdat = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b", b, n, t, r);
        repeat (40) @(negedge clk);
        n_cmp++; if (done_cnt - dbase !== 1) begin n_bad++; $display("FAIL b2b_done_pulses got %0d want 1", done_cnt - dbase); end
        n_cmp++; if (log_n - base !== 11) begin n_bad++; $display("FAIL b2b_count got %0d want 11", log_n - base); end
        n_cmp++; if (log_q[base+6] !== W(8'h44,8'hA5)) begin n_bad++; $display("FAIL b2b_data got %h want %h", log_q[base+6], W(8'h44,8'hA5)); end
    endtask

    task automatic test_reset_mid();
        logic b, n, t; logic [7:0] r;
        bit hit = 0;
        int base = log_n;
        mode = 2; sr_base = sr_total;
        start_txn(1'b0, 7'h48, 8'h01, 8'hA5);
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (log_n - base >= 4 && mcnt == 2 && maddr == 8'h45) hit = 1;
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL rstmid_reach_poll got 0 want 1"); end
        rst = 1'b1;                 // done rises on this same edge
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({busy, done, nack, tmo, rdData} !== 12'd0) begin n_bad++; $display("FAIL rstmid_outputs got %h want 0", {busy, done, nack, tmo, rdData}); end
        n_cmp++; if (wb_if.wbBegin !== 1'b0) begin n_bad++; $display("FAIL rstmid_begin got %b want 0", wb_if.wbBegin); end
        mode = 0;
        base = log_n;
        rd = 1'b0; dev = 7'h48; regA = 8'h01; wdat = 8'hA5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("rstmid", b, n, t, r);
        repeat (20) @(negedge clk);
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL rstmid_begin_while_done got %0d want 0", viol); end
        n_cmp++; if (log_n - base !== 11) begin n_bad++; $display("FAIL rstmid_count got %0d want 11", log_n - base); end
        n_cmp++; if (log_q[base] !== W(8'h44,8'h90)) begin n_bad++; $display("FAIL rstmid_first got %h want %h", log_q[base], W(8'h44,8'h90)); end
        n_cmp++; if ({n, t} !== 2'b00) begin n_bad++; $display("FAIL rstmid_flags got %b want 00", {n, t}); end
    endtask

    initial begin
        test_reset();
`ifdef I2C_INIT_EN
        test_init();
`endif
        test_write();
        test_read();
        test_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
